com_cs_mc: RTL

Multi-channel successor to the single-requester communication control sequencer. It arbitrates N_CH independent send requesters onto one TX frame engine with round-robin fairness and forwards each received packet type to the read consumer. Each transfer uses an fs/fd level handshake. It sits between the application-side producers and the com TX/RX engines, in the system clock domain.

---
 rtl/com_pkg.sv | 22 ++
 rtl/com_rr_arb.sv | 31 +++
 rtl/com_cs_mc.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/com_pkg.sv
// Shared types and default widths for the com_cs_mc multi-channel sequencer.
package com_pkg;

    localparam int BTYPE_W_DEF = 4;
    localparam int DLEN_W_DEF  = 12;
    localparam int ADDR_W_DEF  = 12;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_DROP,
        TX_DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_ARM,
        RX_WAIT,
        RX_NOTIFY,
        RX_CLEAR
    } rx_state_t;

endpackage

// File: rtl/com_rr_arb.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr.
module com_rr_arb #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_CH-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int i = 0; i < N_CH; i++) begin
            w_j = int'(i_ptr) + i;
            if (w_j >= N_CH) w_j = w_j - N_CH;
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/com_cs_mc.sv
// Multi-channel com control sequencer: round-robin TX arbitration plus an independent RX notify path.
// Optional COM_TIMEOUT_EN adds a SEND watchdog and the sticky tx_err output.
module com_cs_mc
    import com_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int BTYPE_W = BTYPE_W_DEF,
    parameter int DLEN_W  = DLEN_W_DEF,
`ifdef COM_TIMEOUT_EN
    parameter int TIMEOUT = 4095,
`endif
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           fs_send,
    input  logic [N_CH*BTYPE_W-1:0]   send_btype,
    input  logic [N_CH*DLEN_W-1:0]    send_dlen,
    input  logic [N_CH*ADDR_W-1:0]    ram_addr_init,
    output logic [N_CH-1:0]           fd_send,
    output logic                      fs_tx,
    input  logic                      fd_tx,
    output logic [BTYPE_W-1:0]        tx_btype,
    output logic [DLEN_W-1:0]         tx_ram_rlen,
    output logic [ADDR_W-1:0]         tx_ram_init,
    output logic [$clog2(N_CH)-1:0]   tx_ch,
    output logic                      fs_rx,
    input  logic                      fd_rx,
    input  logic [BTYPE_W-1:0]        rx_btype,
    output logic                      fs_read,
    output logic [BTYPE_W-1:0]        read_btype,
    input  logic                      fd_read
`ifdef COM_TIMEOUT_EN
    ,
    output logic                      tx_err
`endif
);

    localparam int IDX_W = $clog2(N_CH);

    tx_state_t        r_tx_st;
    rx_state_t        r_rx_st;
    logic [IDX_W-1:0] r_ptr;
    logic [N_CH-1:0]  r_gnt;
    logic [N_CH-1:0]  w_grant;
    logic [IDX_W-1:0] w_gidx;

    com_rr_arb #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (fs_send),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

`ifdef COM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
`endif

    // TX: the one-hot grant is kept so DONE can watch only the served channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_st     <= TX_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            fd_send     <= '0;
            fs_tx       <= 1'b0;
            tx_btype    <= '0;
            tx_ram_rlen <= '0;
            tx_ram_init <= '0;
            tx_ch       <= '0;
`ifdef COM_TIMEOUT_EN
            r_cnt       <= '0;
            tx_err      <= 1'b0;
`endif
        end else begin
            case (r_tx_st)
                TX_IDLE: begin
                    if (|fs_send) begin
                        r_gnt       <= w_grant;
                        tx_ch       <= w_gidx;
                        tx_btype    <= send_btype[int'(w_gidx)*BTYPE_W +: BTYPE_W];
                        tx_ram_rlen <= send_dlen[int'(w_gidx)*DLEN_W +: DLEN_W];
                        tx_ram_init <= ram_addr_init[int'(w_gidx)*ADDR_W +: ADDR_W];
                        fs_tx       <= 1'b1;
`ifdef COM_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                        r_tx_st     <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (fd_tx) begin
                        fs_tx   <= 1'b0;
                        r_tx_st <= TX_DROP;
                    end
`ifdef COM_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        fs_tx   <= 1'b0;
                        tx_err  <= 1'b1;
                        r_tx_st <= TX_DROP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                TX_DROP: begin
                    if (!fd_tx) begin
                        fd_send <= r_gnt;
                        r_tx_st <= TX_DONE;
                    end
                end
                TX_DONE: begin
                    if ((fs_send & r_gnt) == '0) begin
                        fd_send <= '0;
                        r_ptr   <= (tx_ch == IDX_W'(N_CH - 1)) ? '0 : tx_ch + 1'b1;
                        r_tx_st <= TX_IDLE;
                    end
                end
                default: r_tx_st <= TX_IDLE;
            endcase
        end
    end

    // RX: ARM is a one-cycle gap before re-arming the engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_st    <= RX_ARM;
            fs_rx      <= 1'b0;
            fs_read    <= 1'b0;
            read_btype <= '0;
        end else begin
            case (r_rx_st)
                RX_ARM: begin
                    fs_rx   <= 1'b1;
                    r_rx_st <= RX_WAIT;
                end
                RX_WAIT: begin
                    if (fd_rx) begin
                        read_btype <= rx_btype;
                        fs_rx      <= 1'b0;
                        fs_read    <= 1'b1;
                        r_rx_st    <= RX_NOTIFY;
                    end
                end
                RX_NOTIFY: begin
                    if (fd_read) begin
                        fs_read <= 1'b0;
                        r_rx_st <= RX_CLEAR;
                    end
                end
                RX_CLEAR: begin
                    if (!fd_read && !fd_rx) r_rx_st <= RX_ARM;
                end
                default: r_rx_st <= RX_ARM;
            endcase
        end
    end

endmodule
